// File: rtl/ps2_cmd_sequencer_pkg.sv
// Shared PS/2 byte codes, sequencer state encoding and small helpers for the
// keyboard command sequencer and its arbiter.
package ps2_cmd_sequencer_pkg;

    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
    localparam logic [7:0] PS2_SET_LEDS  = 8'hED;
    localparam logic [7:0] PS2_RESET     = 8'hFF;
    localparam logic [7:0] PS2_TYPEMATIC = 8'hF3;
    localparam logic [7:0] PS2_BREAK     = 8'hF0;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitAck,
        StDone,
        StErr
    } seq_state_e;

    // Bytes the keyboard uses to answer a host command.
    function automatic logic is_handshake(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_RESEND);
    endfunction

endpackage

// File: rtl/ps2_cmd_sequencer_rr_arbiter.sv
// Round-robin arbiter: combinational grant starting at a registered pointer;
// the pointer moves past the winner whenever a grant is taken.
module ps2_cmd_sequencer_rr_arbiter #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx,
    output logic            any
);

    logic [IdxW-1:0] ptr_q;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            logic [IdxW-1:0] cand;
            cand = IdxW'((32'(ptr_q) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance && any) begin
            ptr_q <= (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Shares the PS/2 host-to-device command path between several requesters, waits for
// ACK after every byte, retries on RESEND and forwards everything else as scan codes.
module ps2_cmd_sequencer
    import ps2_cmd_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ACK_TIMEOUT = 2_500_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_cmd,
    input  logic [8*NUM_REQ-1:0] req_arg,
    input  logic [NUM_REQ-1:0]   req_has_arg,
    output logic [NUM_REQ-1:0]   req_grant,
    output logic [NUM_REQ-1:0]   req_done,
    output logic [NUM_REQ-1:0]   req_err,
    output logic                 busy,
    output logic [7:0]           the_command,
    output logic                 send_command,
    input  logic                 command_was_sent,
    input  logic                 error_communication_timed_out,
    input  logic [7:0]           received_data,
    input  logic                 received_data_en,
    output logic [7:0]           scan_data,
    output logic                 scan_data_en
);

    localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TimerW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(ACK_TIMEOUT - 1);

    seq_state_e          state_q;
    logic [IdxW-1:0]     idx_q;
    logic [7:0]          arg_q;
    logic                has_arg_q;
    logic                on_arg_q;
    logic [RetryW-1:0]   retry_q;
    logic [TimerW-1:0]   timer_q;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_any;
    logic [NUM_REQ-1:0]  owner;
    logic                rx_ack;
    logic                rx_resend;
    logic                consume;

    ps2_cmd_sequencer_rr_arbiter #(
        .N    (NUM_REQ),
        .IdxW (IdxW)
    ) u_arb (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .req       (req),
        .advance   (state_q == StIdle),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign owner     = NUM_REQ'(1) << idx_q;
    assign rx_ack    = received_data_en && (received_data == PS2_ACK);
    assign rx_resend = received_data_en && (received_data == PS2_RESEND);
    // Handshake bytes belong to us only once the byte is on the wire; before that
    // they are ordinary scan codes.
    assign consume   = is_handshake(received_data) &&
                       (state_q inside {StWaitAck, StDone, StErr});

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            arg_q        <= '0;
            has_arg_q    <= 1'b0;
            on_arg_q     <= 1'b0;
            retry_q      <= '0;
            timer_q      <= '0;
            req_grant    <= '0;
            req_done     <= '0;
            req_err      <= '0;
            busy         <= 1'b0;
            the_command  <= 8'h00;
            send_command <= 1'b0;
            scan_data    <= 8'h00;
            scan_data_en <= 1'b0;
        end else begin
            req_grant    <= '0;
            req_done     <= '0;
            req_err      <= '0;
            scan_data_en <= received_data_en && !consume;
            if (received_data_en && !consume) begin
                scan_data <= received_data;
            end

            unique case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        req_grant    <= arb_grant;
                        idx_q        <= arb_idx;
                        the_command  <= req_cmd[8*arb_idx +: 8];
                        arg_q        <= req_arg[8*arb_idx +: 8];
                        has_arg_q    <= req_has_arg[arb_idx];
                        on_arg_q     <= 1'b0;
                        retry_q      <= '0;
                        busy         <= 1'b1;
                        send_command <= 1'b1;
                        state_q      <= StSend;
                    end
                end
                StSend: begin
                    if (error_communication_timed_out) begin
                        send_command <= 1'b0;
                        req_err      <= owner;
                        state_q      <= StErr;
                    end else if (command_was_sent) begin
                        send_command <= 1'b0;
                        timer_q      <= '0;
                        state_q      <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (rx_ack) begin
                        if (!on_arg_q && has_arg_q) begin
                            on_arg_q     <= 1'b1;
                            retry_q      <= '0;
                            the_command  <= arg_q;
                            send_command <= 1'b1;
                            state_q      <= StSend;
                        end else begin
                            req_done <= owner;
                            state_q  <= StDone;
                        end
                    end else if (rx_resend) begin
                        // Incremented count would exceed the limit: give up on this byte.
                        if (retry_q == RetryW'(MAX_RETRY)) begin
                            req_err <= owner;
                            state_q <= StErr;
                        end else begin
                            retry_q      <= retry_q + 1'b1;
                            send_command <= 1'b1;
                            state_q      <= StSend;
                        end
                    end else if (timer_q == TimeoutLast) begin
                        req_err <= owner;
                        state_q <= StErr;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StDone, StErr: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed and randomized bench for ps2_cmd_sequencer; the bench plays the PS/2
// controller and predicts grants, byte sequences and outcomes from the command rules.
module tb_ps2_cmd_sequencer;
    import ps2_cmd_sequencer_pkg::*;

    localparam int NUM_REQ     = 2;
    localparam int ACK_TIMEOUT = 100;
    localparam int MAX_RETRY   = 3;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_cmd, req_arg;
    logic [1:0]  req_has_arg;
    logic [1:0]  req_grant, req_done, req_err;
    logic        busy;
    logic [7:0]  the_command;
    logic        send_command;
    logic        command_was_sent;
    logic        error_communication_timed_out;
    logic [7:0]  received_data;
    logic        received_data_en;
    logic [7:0]  scan_data;
    logic        scan_data_en;

    logic [7:0]  cmd_of[2];
    logic [7:0]  arg_of[2];
    logic        has_arg_of[2];

    assign req_cmd     = {cmd_of[1], cmd_of[0]};
    assign req_arg     = {arg_of[1], arg_of[0]};
    assign req_has_arg = {has_arg_of[1], has_arg_of[0]};

    ps2_cmd_sequencer #(
        .NUM_REQ     (NUM_REQ),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .CLOCK_50                      (CLOCK_50),
        .reset                         (reset),
        .req                           (req),
        .req_cmd                       (req_cmd),
        .req_arg                       (req_arg),
        .req_has_arg                   (req_has_arg),
        .req_grant                     (req_grant),
        .req_done                      (req_done),
        .req_err                       (req_err),
        .busy                          (busy),
        .the_command                   (the_command),
        .send_command                  (send_command),
        .command_was_sent              (command_was_sent),
        .error_communication_timed_out (error_communication_timed_out),
        .received_data                 (received_data),
        .received_data_en              (received_data_en),
        .scan_data                     (scan_data),
        .scan_data_en                  (scan_data_en)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_assert = 0;
    int n_fail   = 0;
    int ptr      = 0;   // model round-robin pointer

    // Monitor: counts done/err pulses and records every distinct SEND phase.
    logic [7:0] sends_log[$];
    int         done_cnt = 0;
    int         err_cnt  = 0;
    logic [1:0] last_done = '0;
    logic [1:0] last_err  = '0;
    logic       send_prev = 1'b0;

    always @(negedge CLOCK_50) begin
        if (req_done != 0) begin
            done_cnt  <= done_cnt + 1;
            last_done <= req_done;
        end
        if (req_err != 0) begin
            err_cnt  <= err_cnt + 1;
            last_err <= req_err;
        end
        if (send_command && !send_prev) sends_log.push_back(the_command);
        send_prev <= send_command;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: observed no end of test, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_sent();
        command_was_sent = 1'b1;
        tick();
        command_was_sent = 1'b0;
    endtask

    // Drive one received byte; the forwarded strobe must appear on the next cycle.
    task automatic pulse_rx(input logic [7:0] b, input bit fwd);
        received_data    = b;
        received_data_en = 1'b1;
        tick();
        received_data_en = 1'b0;
        check("scan_en", {31'd0, scan_data_en}, {31'd0, fwd});
        if (fwd) check("scan_data", {24'd0, scan_data}, {24'd0, b});
    endtask

    function automatic logic [7:0] scan_byte();
        logic [7:0] b;
        case ($urandom_range(0, 3))
            0:       b = PS2_BAT_OK;
            1:       b = PS2_BREAK;
            default: b = 8'($urandom_range(0, 255));
        endcase
        if (b == 8'hFA || b == 8'hFE || b == 8'h00) b = 8'h1C;
        return b;
    endfunction

    // Raise the masked requests and expect the round-robin winner from the model.
    task automatic arbitrate(input logic [1:0] mask, output int who);
        int k;
        req = req | mask;
        who = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            int c;
            c = (ptr + i) % NUM_REQ;
            if (who < 0 && req[c]) who = c;
        end
        k = 0;
        do begin
            tick();
            k++;
        end while (req_grant == 0 && k < 10);
        check("grant", {30'd0, req_grant}, 32'(1 << who));
        check("grant_cmd", {24'd0, the_command}, {24'd0, cmd_of[who]});
        check("grant_busy", {31'd0, busy}, 32'd1);
        ptr = (who + 1) % NUM_REQ;
        req[who] = 1'b0;
    endtask

    // Act as the PS/2 controller for the granted command; fe0/fe1 RESENDs are given
    // for each byte before ACKing it.
    task automatic serve(input int who, input int fe0, input int fe1, input logic [7:0] inj,
                         input bit early_rx);
        logic [7:0] exp_q[$];
        bit         exp_err;
        int         fe[2];
        int         n, d0, e0, pos, given, k, nbytes;
        fe[0]   = fe0;
        fe[1]   = fe1;
        exp_err = 0;
        nbytes  = has_arg_of[who] ? 2 : 1;
        for (int b = 0; b < nbytes; b++) begin
            n = (fe[b] > MAX_RETRY) ? MAX_RETRY + 1 : fe[b] + 1;
            for (int r = 0; r < n; r++) exp_q.push_back(b == 0 ? cmd_of[who] : arg_of[who]);
            if (fe[b] > MAX_RETRY) begin
                exp_err = 1;
                break;
            end
        end

        sends_log.delete();
        d0    = done_cnt;
        e0    = err_cnt;
        pos   = 0;
        given = 0;
        if (early_rx) pulse_rx(PS2_ACK, 1);
        for (int g = 0; g < 40; g++) begin
            k = 0;
            while (!send_command && done_cnt == d0 && err_cnt == e0 && k < 30) begin
                tick();
                k++;
            end
            if (!send_command) break;
            repeat ($urandom_range(0, 2)) tick();
            pulse_sent();
            check("send_drop", {31'd0, send_command}, 32'd0);
            repeat ($urandom_range(0, 2)) tick();
            if (inj != 8'h00) pulse_rx(inj, 1);
            if (given < fe[pos]) begin
                pulse_rx(PS2_RESEND, 0);
                given++;
            end else begin
                pulse_rx(PS2_ACK, 0);
                pos++;
                given = 0;
            end
        end
        check("done_count", 32'(done_cnt - d0), exp_err ? 32'd0 : 32'd1);
        check("err_count", 32'(err_cnt - e0), exp_err ? 32'd1 : 32'd0);
        check("result_owner", {30'd0, exp_err ? last_err : last_done}, 32'(1 << who));
        check("send_count", 32'(sends_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sends_log.size(); i++)
            check("send_byte", {24'd0, sends_log[i]}, {24'd0, exp_q[i]});
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int who, k, d0, e0;
        logic [7:0] picks[3];
        picks[0] = PS2_SET_LEDS;
        picks[1] = PS2_RESET;
        picks[2] = PS2_TYPEMATIC;

        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < 2; i++) begin
            cmd_of[i]     = 8'h00;
            arg_of[i]     = 8'h00;
            has_arg_of[i] = 1'b0;
        end
        command_was_sent              = 1'b0;
        error_communication_timed_out = 1'b0;
        received_data                 = 8'h00;
        received_data_en              = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'({req_grant, req_done, req_err, busy, the_command,
                                    send_command, scan_data, scan_data_en}), 32'd0);
        reset = 1'b0;
        tick();

        // Single-byte reset command.
        cmd_of[0] = PS2_RESET;
        arbitrate(2'b01, who);
        serve(who, 0, 0, 8'h00, 0);

        // Two-byte LED update.
        cmd_of[1]     = PS2_SET_LEDS;
        arg_of[1]     = 8'h07;
        has_arg_of[1] = 1'b1;
        arbitrate(2'b10, who);
        serve(who, 0, 0, 8'h00, 0);

        // Simultaneous requests, twice.
        cmd_of[0]     = PS2_TYPEMATIC;
        arg_of[0]     = 8'h20;
        has_arg_of[0] = 1'b1;
        repeat (2) begin
            arbitrate(2'b11, who);
            check("pair_first", 32'(who), 32'd0);
            serve(who, 0, 0, 8'h00, 0);
            arbitrate(2'b00, who);
            check("pair_second", 32'(who), 32'd1);
            serve(who, 0, 0, 8'h00, 0);
        end

        // RESEND retries: three tolerated, fourth fails before the argument.
        arbitrate(2'b10, who);
        serve(who, 3, 0, 8'h00, 0);
        arbitrate(2'b10, who);
        serve(who, 4, 0, 8'h00, 0);

        // ACK timeout.
        cmd_of[0]     = PS2_RESET;
        has_arg_of[0] = 1'b0;
        arbitrate(2'b01, who);
        pulse_sent();
        k = 0;
        while (req_err == 0 && k < 150) begin
            tick();
            k++;
        end
        check("timeout_cycles", 32'(k), 32'(ACK_TIMEOUT));
        check("timeout_err", {30'd0, req_err}, 32'(1 << who));
        tick();
        check("timeout_busy", {31'd0, busy}, 32'd0);

        // Controller timeout in SEND while another request arrives: error first.
        arbitrate(2'b01, who);
        tick();
        error_communication_timed_out = 1'b1;
        req[1] = 1'b1;
        tick();
        error_communication_timed_out = 1'b0;
        check("send_timeout_err", {30'd0, req_err}, 32'(1 << who));
        check("send_timeout_nogrant", {30'd0, req_grant}, 32'd0);
        arbitrate(2'b00, who);
        check("after_err_grant", 32'(who), 32'd1);
        serve(who, 0, 1, 8'h00, 0);

        // Scan forwarding: everything in IDLE, non-handshake bytes while busy.
        pulse_rx(PS2_ACK, 1);
        pulse_rx(PS2_RESEND, 1);
        pulse_rx(8'h33, 1);
        arbitrate(2'b01, who);
        serve(who, 0, 0, 8'h33, 0);
        arbitrate(2'b10, who);
        serve(who, 1, 0, PS2_BAT_OK, 1);

        // Reset while waiting for ACK aborts silently and clears the pointer.
        arbitrate(2'b01, who);
        pulse_sent();
        tick();
        d0 = done_cnt;
        e0 = err_cnt;
        #2 reset = 1'b1;
        #1;
        check("midreset_outputs", 32'({req_grant, req_done, req_err, busy, the_command,
                                       send_command, scan_data, scan_data_en}), 32'd0);
        repeat (3) tick();
        check("midreset_done", 32'(done_cnt - d0), 32'd0);
        check("midreset_err", 32'(err_cnt - e0), 32'd0);
        reset = 1'b0;
        ptr   = 0;
        tick();
        arbitrate(2'b11, who);
        serve(who, 0, 0, 8'h00, 0);
        arbitrate(2'b00, who);
        serve(who, 0, 0, 8'h00, 0);

        // Randomized traffic.
        for (int t = 0; t < 14; t++) begin
            for (int r = 0; r < 2; r++) begin
                cmd_of[r]     = picks[$urandom_range(0, 2)];
                arg_of[r]     = 8'($urandom_range(0, 255));
                has_arg_of[r] = 1'($urandom_range(0, 1));
            end
            arbitrate(2'($urandom_range(1, 3)), who);
            serve(who, $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 1) ? scan_byte() : 8'h00, 0);
            while (req != 0) begin
                arbitrate(2'b00, who);
                serve(who, $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 1) ? scan_byte() : 8'h00, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
